axi_strm_tx: RTL and testbench

- AXI master that pushes a 512-bit+1-bit-user stream into a remote credit-based stream endpoint.
- The endpoint exposes a credit register (newly freed space, consumed on read) at offset 0x40; any non-status offset is its data FIFO.
- Buffers an incoming valid/ready stream locally, polls the endpoint's write-credit register over AR/R, then issues INCR write bursts sized to available credits.
- Sits on the producer side of a stream channel, with its AXI master port routed to the endpoint.

---
 rtl/axi_strm_tx.sv | 201 ++++++++++++++++++++
 tb/tb_axi_strm_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_strm_tx.sv
// AXI stream transmitter: buffers a 513-bit (data + user) stream locally,
// polls the remote endpoint's credit register, then writes INCR bursts no
// longer than the credits currently held.
module axi_strm_tx #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter logic [63:0] CRED_OFF  = 64'h40,
  parameter logic [63:0] DATA_OFF  = 64'h100,
  parameter int          MAX_BURST = 16,
  parameter int          CRED_W    = 15,
  parameter int          BUF_LD    = 6,
  parameter int          POLL_GAP  = 64,
  parameter logic [15:0] AXI_ID    = 16'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              s_valid,
  input  logic [511:0]      s_data,
  input  logic              s_user,
  output logic              s_ready,
  // AR channel
  output logic [15:0]       axi_arid,
  output logic [63:0]       axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  // R channel
  input  logic [511:0]      axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  // AW channel
  output logic [15:0]       axi_awid,
  output logic [63:0]       axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic [2:0]        axi_awsize,
  output logic [1:0]        axi_awburst,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  // W channel
  output logic [511:0]      axi_wdata,
  output logic [63:0]       axi_wstrb,
  output logic              axi_wuser,
  output logic              axi_wlast,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  // B channel
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  // status
  output logic [CRED_W-1:0] credits,
  output logic [31:0]       beats_sent,
  output logic              err,
  output logic              busy
);

  localparam int DEPTH = 1 << BUF_LD;
  localparam int LEN_W = $clog2(MAX_BURST + 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_WAIT, S_CRED_AR, S_CRED_R, S_AW, S_W, S_B
  } state_t;

  state_t state_reg, state_next;

  logic [CRED_W-1:0] credits_reg;
  logic [LEN_W-1:0]  burst_len_reg, beat_cnt_reg;
  logic [15:0]       poll_cnt_reg;
  logic [31:0]       beats_sent_reg;
  logic              err_reg;

  logic [512:0]      mem [DEPTH];
  logic [BUF_LD-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [BUF_LD:0]   count_reg;

  logic              push, pop, w_hs;
  logic [CRED_W-1:0] cred_add;
  logic [LEN_W-1:0]  cred_sat, cnt_sat, len_sel;
  logic              unused_rdata;

  assign cred_add     = axi_rdata[CRED_W-1:0];
  assign unused_rdata = ^axi_rdata[511:CRED_W];

  assign s_ready = rst_n && (count_reg != (BUF_LD+1)'(DEPTH));
  assign push    = s_valid && s_ready;
  assign w_hs    = axi_wvalid && axi_wready;
  assign pop     = w_hs;

  // Constant AXI attributes
  assign axi_arid    = AXI_ID;
  assign axi_awid    = AXI_ID;
  assign axi_arsize  = 3'd6;
  assign axi_awsize  = 3'd6;
  assign axi_arburst = 2'b01;
  assign axi_awburst = 2'b01;
  assign axi_araddr  = BASE_ADDR + CRED_OFF;
  assign axi_awaddr  = BASE_ADDR + DATA_OFF;
  assign axi_arlen   = 8'd0;
  assign axi_awlen   = 8'(burst_len_reg - LEN_W'(1));
  assign axi_wstrb   = '1;
  assign {axi_wuser, axi_wdata} = mem[rd_ptr_reg];

  assign credits    = credits_reg;
  assign beats_sent = beats_sent_reg;
  assign err        = err_reg;

  // Burst length = min(credits, buffered beats, MAX_BURST)
  always_comb begin
    cred_sat = (32'(credits_reg) > 32'(MAX_BURST)) ? LEN_W'(MAX_BURST) : LEN_W'(credits_reg);
    cnt_sat  = (32'(count_reg) > 32'(MAX_BURST)) ? LEN_W'(MAX_BURST) : LEN_W'(count_reg);
    len_sel  = (cnt_sat < cred_sat) ? cnt_sat : cred_sat;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (en && count_reg != '0)
                     state_next = (credits_reg == '0) ? S_CRED_AR : S_AW;
      S_CRED_AR:   if (axi_arready) state_next = S_CRED_R;
      S_CRED_R:    if (axi_rvalid)
                     state_next = (axi_rresp == 2'b00 && cred_add != '0) ? S_IDLE : S_POLL_WAIT;
      S_POLL_WAIT: if (poll_cnt_reg == POLL_LAST) state_next = S_IDLE;
      S_AW:        if (axi_awready) state_next = S_W;
      S_W:         if (w_hs && axi_wlast) state_next = S_B;
      S_B:         if (axi_bvalid) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // FSM outputs: channel valids/readies decoded from state
  always_comb begin
    axi_arvalid = (state_reg == S_CRED_AR);
    axi_rready  = (state_reg == S_CRED_R);
    axi_awvalid = (state_reg == S_AW);
    axi_wvalid  = (state_reg == S_W) && (count_reg != '0);
    axi_wlast   = (beat_cnt_reg == burst_len_reg - LEN_W'(1));
    axi_bready  = (state_reg == S_B);
    busy        = (state_reg != S_IDLE);
  end

  // Credits, burst bookkeeping, counters and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_reg    <= '0;
      burst_len_reg  <= '0;
      beat_cnt_reg   <= '0;
      poll_cnt_reg   <= '0;
      beats_sent_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && en && count_reg != '0 && credits_reg != '0)
        burst_len_reg <= len_sel;
      if (state_reg == S_CRED_R && axi_rvalid) begin
        if (axi_rresp == 2'b00) credits_reg <= credits_reg + cred_add;
        else                    err_reg     <= 1'b1;
      end
      poll_cnt_reg <= (state_reg == S_POLL_WAIT) ? poll_cnt_reg + 16'd1 : 16'd0;
      if (state_reg == S_AW && axi_awready) begin
        credits_reg  <= credits_reg - CRED_W'(burst_len_reg);
        beat_cnt_reg <= '0;
      end
      if (w_hs) begin
        beat_cnt_reg   <= beat_cnt_reg + LEN_W'(1);
        beats_sent_reg <= beats_sent_reg + 32'd1;
      end
      if (state_reg == S_B && axi_bvalid && axi_bresp != 2'b00)
        err_reg <= 1'b1;
    end
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + BUF_LD'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + BUF_LD'(1);
      if (push && !pop)      count_reg <= count_reg + (BUF_LD+1)'(1);
      else if (pop && !push) count_reg <= count_reg - (BUF_LD+1)'(1);
    end
  end

  // Input FIFO storage (no reset; validity tracked by pointers)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {s_user, s_data};
  end

endmodule

// File: tb/tb_axi_strm_tx.sv
// Directed bench for axi_strm_tx: the bench plays the remote endpoint,
// answering credit polls and write bursts and checking every beat.
module tb_axi_strm_tx;

  logic         clk = 1'b0;
  logic         rst_n, en, s_valid, s_user, s_ready;
  logic [511:0] s_data;
  logic [15:0]  axi_arid, axi_awid;
  logic [63:0]  axi_araddr, axi_awaddr, axi_wstrb;
  logic [7:0]   axi_arlen, axi_awlen;
  logic [2:0]   axi_arsize, axi_awsize;
  logic [1:0]   axi_arburst, axi_awburst, axi_rresp, axi_bresp;
  logic         axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic         axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast, axi_wuser;
  logic         axi_bvalid, axi_bready;
  logic [511:0] axi_rdata, axi_wdata;
  logic [14:0]  credits;
  logic [31:0]  beats_sent;
  logic         err, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] tx_seq = 32'd0;
  logic [31:0] rx_seq = 32'd0;

  always #5 clk = ~clk;

  axi_strm_tx dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .s_valid(s_valid), .s_data(s_data), .s_user(s_user), .s_ready(s_ready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wuser(axi_wuser), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .credits(credits), .beats_sent(beats_sent), .err(err), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input logic [31:0] seq);
    logic [31:0] w;
    w = seq ^ 32'hC0DE0000;
    return {w, w};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; s_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx_seq = tx_seq;
  endtask

  task automatic push_beats(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w       = tx_seq ^ 32'hC0DE0000;
      s_valid = 1'b1;
      s_user  = tx_seq[0];
      s_data  = {16{w}};
      tx_seq  = tx_seq + 32'd1;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic cred_poll(input logic [31:0] reply, input logic [1:0] resp);
    int n = 0;
    while (!axi_arvalid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!axi_arvalid) begin
      check("ar_timeout", 64'd0, 64'd1);
      return;
    end
    check("araddr", axi_araddr, 64'h40);
    check("arlen", 64'(axi_arlen), 64'd0);
    axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0;
    check("rready", 64'(axi_rready), 64'd1);
    axi_rvalid = 1'b1;
    axi_rdata  = 512'(reply);
    axi_rresp  = resp;
    @(negedge clk);
    axi_rvalid = 1'b0;
    $display("poll: reply %0d resp %0d -> credits %0d", reply, resp, credits);
  endtask

  // Serve one write burst; stall_beat drops wready for 4 cycles on that beat,
  // abort_beat asserts reset just before that beat's handshake.
  task automatic burst(input int len, input logic [1:0] bresp, input int stall_beat, input int abort_beat);
    int n = 0;
    logic [31:0] bs0;
    while (!axi_awvalid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!axi_awvalid) begin
      check("aw_timeout", 64'd0, 64'd1);
      return;
    end
    check("awaddr", axi_awaddr, 64'h100);
    check("awlen", 64'(axi_awlen), 64'(len - 1));
    bs0 = beats_sent;
    axi_awready = 1'b1;
    @(negedge clk);
    axi_awready = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == abort_beat) begin
        rst_n = 1'b0;
        #1;
        check("abort_wvalid", 64'(axi_wvalid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_s_ready", 64'(s_ready), 64'd0);
        check("abort_credits", 64'(credits), 64'd0);
        rx_seq = tx_seq;
        $display("burst: len %0d aborted by reset at beat %0d", len, i);
        return;
      end
      if (i == stall_beat) begin
        axi_wready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          check("stall_wvalid", 64'(axi_wvalid), 64'd1);
          check("stall_wdata", axi_wdata[63:0], beat_word(rx_seq));
          check("stall_wuser", 64'(axi_wuser), 64'(rx_seq[0]));
          check("stall_wlast", 64'(axi_wlast), 64'(i == len - 1));
          check("stall_no_pop", 64'(beats_sent), 64'(bs0 + 32'(i)));
          @(negedge clk);
        end
      end
      axi_wready = 1'b1;
      check("wvalid", 64'(axi_wvalid), 64'd1);
      check("wdata", axi_wdata[63:0], beat_word(rx_seq));
      check("wuser", 64'(axi_wuser), 64'(rx_seq[0]));
      check("wlast", 64'(axi_wlast), 64'(i == len - 1));
      @(negedge clk);
      axi_wready = 1'b0;
      rx_seq = rx_seq + 32'd1;
    end
    check("beats_after_w", 64'(beats_sent), 64'(bs0 + 32'(len)));
    check("bready", 64'(axi_bready), 64'd1);
    axi_bvalid = 1'b1;
    axi_bresp  = bresp;
    @(negedge clk);
    axi_bvalid = 1'b0;
    $display("burst: len %0d bresp %0d -> credits %0d beats_sent %0d", len, bresp, credits, beats_sent);
  endtask

  // Wait for the next credit poll, returning cycles waited and any AW seen
  task automatic wait_repoll(output int gap, output logic aw_seen);
    gap = 0;
    aw_seen = 1'b0;
    while (!axi_arvalid && gap < 300) begin
      @(negedge clk);
      gap++;
      if (axi_awvalid) aw_seen = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    logic aw_seen;
    logic ar_seen;
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_user = 1'b0; s_data = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_arvalid", 64'(axi_arvalid), 64'd0);
    check("rst_awvalid", 64'(axi_awvalid), 64'd0);
    check("rst_wvalid", 64'(axi_wvalid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_credits", 64'(credits), 64'd0);
    check("post_rst_beats", 64'(beats_sent), 64'd0);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_err", 64'(err), 64'd0);
    check("const_wstrb", axi_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
    check("const_size_burst", 64'({axi_arsize, axi_awsize, axi_arburst, axi_awburst}), 64'({3'd6, 3'd6, 2'b01, 2'b01}));

    // Three beats, large credit grant
    rx_seq = tx_seq;
    push_beats(3);
    en = 1'b1;
    cred_poll(32'd16384, 2'b00);
    check("credits_16384", 64'(credits), 64'd16384);
    burst(3, 2'b00, -1, -1);
    check("credits_16381", 64'(credits), 64'd16381);
    check("beats_3", 64'(beats_sent), 64'd3);

    // 40 beats against 100 credits -> 16,16,8
    do_reset();
    push_beats(40);
    en = 1'b1;
    cred_poll(32'd100, 2'b00);
    burst(16, 2'b00, -1, -1);
    burst(16, 2'b00, -1, -1);
    burst(8, 2'b00, -1, -1);
    @(negedge clk);
    check("credits_60", 64'(credits), 64'd60);
    check("beats_40", 64'(beats_sent), 64'd40);
    check("idle_after_40", 64'(busy), 64'd0);

    // Zero-credit reply -> poll gap, then partial grant
    do_reset();
    push_beats(8);
    en = 1'b1;
    cred_poll(32'd0, 2'b00);
    wait_repoll(gap, aw_seen);
    check("poll_gap", 64'(gap), 64'd65);
    check("no_aw_zero_cred", 64'(aw_seen), 64'd0);
    cred_poll(32'd5, 2'b00);
    burst(5, 2'b00, -1, -1);
    cred_poll(32'd0, 2'b00);
    check("credits_zero_wait", 64'(credits), 64'd0);
    wait_repoll(gap, aw_seen);
    check("no_aw_waiting", 64'(aw_seen), 64'd0);
    cred_poll(32'd3, 2'b00);
    burst(3, 2'b00, -1, -1);
    check("beats_8", 64'(beats_sent), 64'd8);

    // Error responses
    do_reset();
    push_beats(4);
    en = 1'b1;
    cred_poll(32'd2, 2'b00);
    burst(2, 2'b10, -1, -1);
    check("err_bresp", 64'(err), 64'd1);
    cred_poll(32'd2, 2'b00);
    burst(2, 2'b00, -1, -1);
    check("err_sticky", 64'(err), 64'd1);
    check("beats_after_err", 64'(beats_sent), 64'd4);
    do_reset();
    check("err_cleared", 64'(err), 64'd0);
    push_beats(1);
    en = 1'b1;
    cred_poll(32'd7, 2'b10);
    check("err_rresp", 64'(err), 64'd1);
    check("rresp_no_credit", 64'(credits), 64'd0);
    cred_poll(32'd1, 2'b00);
    burst(1, 2'b00, -1, -1);

    // Backpressure on beat 2, then reset mid-burst
    do_reset();
    push_beats(5);
    en = 1'b1;
    cred_poll(32'd5, 2'b00);
    burst(5, 2'b00, 1, 3);
    @(negedge clk);
    rst_n = 1'b1;
    ar_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_arvalid) ar_seen = 1'b1;
    end
    check("fifo_empty_no_poll", 64'(ar_seen), 64'd0);
    check("beats_after_abort", 64'(beats_sent), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
